// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encoding
// of the HI/LO-class instructions and the sequencer state type.
package ex_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // True for the ops that need the iterative datapath (MULT..DIVU)
  function automatic logic is_iterative(input logic [2:0] o);
    return (o <= OP_DIVU);
  endfunction

endpackage

// File: rtl/abs_sign.sv
// Magnitude and sign extraction of a possibly signed operand; unsigned
// operands pass through untouched with a clear sign flag.
module abs_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         is_signed,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = is_signed & value[W-1];
  assign mag = neg ? -value : value;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO. One radix-2 step per
// cycle on magnitudes, followed by a sign-fix cycle that writes HI/LO.
// The multiplier (or dividend) starts in the low half of the accumulator
// and is consumed one bit per step while the result fills in. XLEN >= 4.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);

  state_t            state, next_state;
  logic [CNT_W-1:0]  counter;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              is_div, neg_res, neg_rem;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_a, neg_b, op_signed;
  logic              accept, fix_write;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  abs_sign #(.W(XLEN)) u_abs_a (
    .value     (a),
    .is_signed (op_signed),
    .mag       (mag_a),
    .neg       (neg_a)
  );

  abs_sign #(.W(XLEN)) u_abs_b (
    .value     (b),
    .is_signed (op_signed),
    .mag       (mag_b),
    .neg       (neg_b)
  );

  // stall_req covers the accept cycle combinationally so EX holds at once
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && start && !flush && is_iterative(op);
  assign stall_req = busy || accept;
  assign fix_write = (state == FIX) && !flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush wins over everything, including the FIX write
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (counter == '0) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // One radix-2 step: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (is_div) begin
      if (!div_diff[XLEN]) step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction applied in FIX; remainder follows the dividend sign
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  // Datapath registers, iteration counter, HI/LO and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      acc     <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= fix_write;
      if (state == IDLE && start && !flush) begin
        if (op == OP_MTHI)      hi <= a;
        else if (op == OP_MTLO) lo <= a;
      end
      if (accept) begin
        acc     <= {{XLEN{1'b0}}, mag_a};
        opb     <= mag_b;
        is_div  <= op[1];
        neg_res <= neg_a ^ neg_b;
        neg_rem <= neg_a;
        counter <= CNT_W'(XLEN - 1);
      end else if (state == RUN) begin
        acc <= step;
        if (counter != '0) counter <= counter - CNT_W'(1);
      end
      if (fix_write) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*XLEN-1:XLEN];
          lo <= prod_fix[XLEN-1:0];
        end
      end
    end
  end

endmodule
